// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule engine and the cipher datapath.
// Contents: round count, rcon seed, GF(2^8) reduction polynomial, byte/word/state
// typedefs, FSM state constants and the xtime (multiply-by-x) helper.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  GF_POLY   = 8'h1b;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // Last round number, sized for the 4-bit round counter.
  localparam logic [3:0] ROUND_LAST = 4'(AES_NR);

  // Key-schedule FSM encodings.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_final_if.sv
// Handshake bundle between the host key register / AES_DEC and aes_key_final.
// master: host side (drives EN, Krdy, Key; observes Dout, BSY, Dvld).
// slave : key-schedule engine side.
interface aes_key_final_if;
  import aes_pkg::*;

  logic   EN;
  logic   Krdy;
  state_t Key;
  state_t Dout;
  logic   BSY;
  logic   Dvld;

  modport master (output EN, Krdy, Key, input Dout, BSY, Dvld);
  modport slave  (input EN, Krdy, Key, output Dout, BSY, Dvld);

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, shared with the cipher datapath.
// Ports: a - input byte; s - substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t s
);

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s = SBOX[a];

endmodule

// File: rtl/aes_key_final.sv
// Forward AES-128 key schedule: expands the cipher key one round per clock and
// delivers the round-10 key for the decryption core.
// Ports: CLK  - clock (rising edge)
//        RSTn - synchronous active-low reset
//        bus  - slave side of aes_key_final_if (EN, Krdy, Key in; Dout, BSY, Dvld out)
module aes_key_final
  import aes_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTn,
  aes_key_final_if.slave   bus
);

  logic [0:0] state;
  logic [3:0] round;
  byte_t      rcon;
  state_t     wkey;
  state_t     dout;
  logic       bsy;
  logic       dvld;

  word_t  w0, w1, w2, w3;
  word_t  rot;
  word_t  sub;
  word_t  t;
  word_t  n0, n1, n2, n3;
  state_t next_key;

  assign w0 = wkey[127:96];
  assign w1 = wkey[95:64];
  assign w2 = wkey[63:32];
  assign w3 = wkey[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
  aes_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
  aes_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
  aes_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

  always_comb begin
    t        = sub ^ {rcon, 24'h0};
    n0       = w0 ^ t;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= ST_IDLE;
      round <= '0;
      rcon  <= RCON_INIT;
      wkey  <= '0;
      dout  <= '0;
      bsy   <= 1'b0;
      dvld  <= 1'b0;
    end else begin
      dvld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.EN && bus.Krdy) begin
            wkey  <= bus.Key;
            round <= 4'd1;
            rcon  <= RCON_INIT;
            bsy   <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          wkey <= next_key;
          rcon <= xtime(rcon);
          if (round == ROUND_LAST) begin
            // Counter parks at the last round rather than stepping past it.
            dout  <= next_key;
            dvld  <= 1'b1;
            bsy   <= 1'b0;
            state <= ST_IDLE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Dout = dout;
  assign bus.BSY  = bsy;
  assign bus.Dvld = dvld;

endmodule

// File: tb/tb_aes_key_final.sv
// Self-checking bench for aes_key_final: directed handshake scenarios plus
// random keys compared with a FIPS-197 style full key expansion.
module tb_aes_key_final;

  logic CLK;
  logic RSTn;
  int   checks;
  int   errors;

  logic [7:0] sbox_ref [256];

  aes_key_final_if bus ();

  aes_key_final dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_final(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one key, optionally drop EN partway through, then wait (bounded)
  // for the result and check latency, BSY duration, value and hold.
  task automatic run_key(input logic [127:0] k, input logic [127:0] exp,
                         input int en_drop_at, input string tag);
    int n;
    int bsy_n;
    bus.Key  = k;
    bus.EN   = 1'b1;
    bus.Krdy = 1'b1;
    tick();
    bus.Krdy = 1'b0;
    n = 0;
    bsy_n = 0;
    while (!bus.Dvld && n < 20) begin
      if (bus.BSY) bsy_n++;
      if (n == en_drop_at) bus.EN = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd10);
    check({tag, "_bsy_cycles"}, 128'(bsy_n), 128'd10);
    check({tag, "_bsy_low_at_done"}, 128'(bus.BSY), 128'd0);
    check({tag, "_dout"}, bus.Dout, exp);
    bus.EN = 1'b1;
    tick();
    check({tag, "_dvld_one_cycle"}, 128'(bus.Dvld), 128'd0);
    check({tag, "_dout_hold"}, bus.Dout, exp);
  endtask

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    logic [127:0] last;
    int dv;

    checks = 0;
    errors = 0;
    build_sbox();

    // Reset state
    RSTn     = 1'b0;
    bus.EN   = 1'b0;
    bus.Krdy = 1'b0;
    bus.Key  = '0;
    tick();
    tick();
    check("reset_dout", bus.Dout, '0);
    check("reset_bsy", 128'(bus.BSY), 128'd0);
    check("reset_dvld", 128'(bus.Dvld), 128'd0);
    RSTn = 1'b1;
    tick();

    // Known-answer keys
    check("model_kat1", ref_final(128'h000102030405060708090a0b0c0d0e0f),
          128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_key(128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5, -1, "kat1");
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, "kat2");
    last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Krdy with EN=0 is ignored
    bus.EN   = 1'b0;
    bus.Key  = rand_key();
    bus.Krdy = 1'b1;
    dv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Dvld || bus.BSY) dv++;
    end
    bus.Krdy = 1'b0;
    check("en0_no_activity", 128'(dv), 128'd0);
    check("en0_dout_unchanged", bus.Dout, last);

    // Krdy during RUN and on the completion edge are ignored; next cycle accepted
    k1 = rand_key();
    k2 = rand_key();
    bus.EN   = 1'b1;
    bus.Key  = k1;
    bus.Krdy = 1'b1;
    tick();
    dv = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4 || i == 10) begin
        bus.Key  = k2;
        bus.Krdy = 1'b1;
      end else begin
        bus.Krdy = 1'b0;
      end
      tick();
      if (bus.Dvld) dv++;
    end
    check("busy_krdy_one_dvld", 128'(dv), 128'd1);
    check("busy_krdy_dout_first", bus.Dout, ref_final(k1));
    tick();
    bus.Krdy = 1'b0;
    check("after_done_accept_bsy", 128'(bus.BSY), 128'd1);
    check("accept_keeps_dout", bus.Dout, ref_final(k1));
    dv = 0;
    for (int i = 0; i < 20 && !bus.Dvld; i++) begin
      tick();
      dv++;
    end
    check("second_key_latency", 128'(dv), 128'd10);
    check("second_key_dout", bus.Dout, ref_final(k2));
    tick();

    // EN dropped mid-run still completes
    k1 = rand_key();
    run_key(k1, ref_final(k1), 3, "en_drop");

    // Reset at round 5 aborts without Dvld
    k1 = rand_key();
    bus.Key  = k1;
    bus.EN   = 1'b1;
    bus.Krdy = 1'b1;
    tick();
    bus.Krdy = 1'b0;
    repeat (5) tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    check("abort_bsy", 128'(bus.BSY), 128'd0);
    check("abort_dout", bus.Dout, '0);
    dv = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Dvld || bus.BSY) dv++;
      tick();
    end
    check("abort_no_dvld", 128'(dv), 128'd0);
    k2 = rand_key();
    run_key(k2, ref_final(k2), -1, "post_abort");

    // Random keys
    for (int r = 0; r < 6; r++) begin
      k1 = rand_key();
      run_key(k1, ref_final(k1), int'($urandom_range(0, 12)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
